// File: rtl/ua_pkg.sv
// Shared UART definitions: receiver FSM state encoding, 8N1 frame constants and a
// constant-evaluable ceiling log2 used to size counters.
package ua_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int   UA_DATA_BITS  = 8;
    localparam logic UA_IDLE_LEVEL = 1'b1;

    // Bits needed to hold the values 0 .. value-1.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/ua_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset to
// ResetValue so the output does not glitch when reset is released.
module ua_sync #(
    parameter logic ResetValue = 1'b1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic din,
    output logic dout
);

    logic meta;

    // NOTE: non-blocking assignments let meta and dout sample their inputs together,
    // giving a true two-stage pipeline regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            meta <= ResetValue;
            dout <= ResetValue;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/ua_receive.sv
// UART 8N1 receiver with a valid/ready holding register for the received byte.
// Defining UA_RX_ERR_EN adds the FramingError and Overrun one-cycle pulse outputs.
module ua_receive
    import ua_pkg::*;
#(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    SIn,
    output logic [UA_DATA_BITS-1:0] DataOut,
    output logic                    DataOutValid,
    input  logic                    DataOutReady
`ifdef UA_RX_ERR_EN
    ,
    output logic                    FramingError,
    output logic                    Overrun
`endif
);

    localparam int SymbolEdgeTime    = ClockFreq / BaudRate;
    localparam int SampleTime        = SymbolEdgeTime / 2;
    localparam int ClockCounterWidth = log2(SymbolEdgeTime);
    localparam int BitCounterWidth   = log2(UA_DATA_BITS);

    localparam logic [ClockCounterWidth-1:0] SampleLast = ClockCounterWidth'(SampleTime - 1);
    localparam logic [ClockCounterWidth-1:0] SymbolLast = ClockCounterWidth'(SymbolEdgeTime - 1);
    localparam logic [ClockCounterWidth-1:0] CountOne   = ClockCounterWidth'(1);
    localparam logic [BitCounterWidth-1:0]   LastBit    = BitCounterWidth'(UA_DATA_BITS - 1);

    logic                         rx_s;
    rx_state_t                    state, state_next;
    logic [ClockCounterWidth-1:0] clock_counter, clock_counter_next;
    logic [BitCounterWidth-1:0]   bit_counter, bit_counter_next;
    logic [UA_DATA_BITS-1:0]      shift, shift_next;
    logic                         stop_edge;
    logic                         byte_done;

    ua_sync #(
        .ResetValue(UA_IDLE_LEVEL)
    ) u_sync (
        .Clock(Clock),
        .Reset(Reset),
        .din  (SIn),
        .dout (rx_s)
    );

    assign stop_edge = (state == RX_STOP) && (clock_counter == SymbolLast);
    assign byte_done = stop_edge && (rx_s == UA_IDLE_LEVEL);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= RX_IDLE;
            clock_counter <= '0;
            bit_counter   <= '0;
        end else begin
            state         <= state_next;
            clock_counter <= clock_counter_next;
            bit_counter   <= bit_counter_next;
        end
    end

    // NOTE: the shift register is pure datapath and is completely rewritten before it
    // is ever copied out, so it carries no reset.
    always_ff @(posedge Clock) begin
        shift <= shift_next;
    end

    // NOTE: every signal driven here gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next         = state;
        clock_counter_next = clock_counter + CountOne;
        bit_counter_next   = bit_counter;
        shift_next         = shift;
        unique case (state)
            RX_IDLE: begin
                // The detection cycle counts as the first cycle of the start bit.
                clock_counter_next = '0;
                if (rx_s != UA_IDLE_LEVEL) begin
                    state_next         = RX_START;
                    clock_counter_next = CountOne;
                end
            end
            RX_START: begin
                if (clock_counter == SampleLast) begin
                    clock_counter_next = '0;
                    bit_counter_next   = '0;
                    state_next         = (rx_s == UA_IDLE_LEVEL) ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clock_counter == SymbolLast) begin
                    clock_counter_next = '0;
                    shift_next         = {rx_s, shift[UA_DATA_BITS-1:1]};
                    if (bit_counter == LastBit) begin
                        state_next = RX_STOP;
                    end else begin
                        bit_counter_next = bit_counter + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (clock_counter == SymbolLast) begin
                    clock_counter_next = '0;
                    state_next         = RX_IDLE;
                end
            end
            default: begin
                state_next         = RX_IDLE;
                clock_counter_next = '0;
            end
        endcase
    end

    // A completed byte is only taken when the holding register is empty or being drained.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            DataOut      <= '0;
            DataOutValid <= 1'b0;
        end else if (byte_done && (!DataOutValid || DataOutReady)) begin
            DataOut      <= shift;
            DataOutValid <= 1'b1;
        end else if (DataOutReady) begin
            DataOutValid <= 1'b0;
        end
    end

`ifdef UA_RX_ERR_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            FramingError <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            FramingError <= stop_edge && (rx_s != UA_IDLE_LEVEL);
            Overrun      <= byte_done && DataOutValid && !DataOutReady;
        end
    end
`endif

endmodule

// File: tb/tb_ua_receive.sv
// Self-checking bench for ua_receive at 100 MHz / 115200 baud: table-driven frames
// plus hand-written glitch, back-to-back overrun and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_ua_receive;
    import ua_pkg::*;

    localparam int BitCycles     = 868;
    localparam int BadStopCycles = 600;
    localparam int ValidLatency  = 8248;
    localparam int GapCycles     = 400;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       SIn = 1'b1;
    logic       DataOutReady = 1'b0;
    logic [7:0] DataOut;
    logic       DataOutValid;
`ifdef UA_RX_ERR_EN
    logic       FramingError;
    logic       Overrun;
`endif

    int total = 0;
    int bad = 0;

    int         cyc = 0;
    logic       valid_q = 1'b0;
    int         rise_cnt = 0;
    int         rise_cyc = 0;
    logic [7:0] rise_data = 8'h00;
    int         high_cnt = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;

    ua_receive dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .SIn         (SIn),
        .DataOut     (DataOut),
        .DataOutValid(DataOutValid),
        .DataOutReady(DataOutReady)
`ifdef UA_RX_ERR_EN
        ,
        .FramingError(FramingError),
        .Overrun     (Overrun)
`endif
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge away from DUT updates.
    always @(negedge Clock) begin
        valid_q <= DataOutValid;
        if (DataOutValid && !valid_q) begin
            rise_cnt  <= rise_cnt + 1;
            rise_cyc  <= cyc;
            rise_data <= DataOut;
        end
        if (DataOutValid) high_cnt <= high_cnt + 1;
`ifdef UA_RX_ERR_EN
        if (FramingError) fe_cnt <= fe_cnt + 1;
        if (Overrun) ov_cnt <= ov_cnt + 1;
`endif
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Drives start, 8 data bits LSB first and stop; a bad stop is held low only long
    // enough to be sampled so the line is high again before any re-triggered start check.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, output int start_cyc);
        @(negedge Clock);
        start_cyc = cyc;
        SIn = 1'b0;
        repeat (BitCycles) @(negedge Clock);
        for (int i = 0; i < 8; i++) begin
            SIn = data[i];
            repeat (BitCycles) @(negedge Clock);
        end
        SIn = stop_bit;
        repeat (stop_bit ? BitCycles : BadStopCycles) @(negedge Clock);
        SIn = 1'b1;
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int rise0, high0, fe0, ov0, start_cyc;
        rise0 = rise_cnt;
        high0 = high_cnt;
        fe0   = fe_cnt;
        ov0   = ov_cnt;
        DataOutReady = v.ready;
        send_frame(v.data, v.stop, start_cyc);
        repeat (GapCycles) @(negedge Clock);
        check({tag, " valid_rises"}, rise_cnt - rise0, v.exp_valid ? 1 : 0);
        if (v.exp_valid) begin
            check({tag, " latency"}, rise_cyc - start_cyc, ValidLatency);
            check({tag, " data"}, {24'h0, rise_data}, {24'h0, v.exp_data});
            check({tag, " valid_cycles"}, high_cnt - high0, 1);
        end
`ifdef UA_RX_ERR_EN
        check({tag, " framing_pulses"}, fe_cnt - fe0, v.stop ? 0 : 1);
        check({tag, " overrun_pulses"}, ov_cnt - ov0, 0);
`endif
    endtask

    initial begin
        #1.5ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        vec_t vecs[3];
        vec_t v;
        int   rise0, high0, ov0, sc;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, ready: 1'b1, exp_valid: 1'b1, exp_data: 8'hA5};
        vecs[1] = '{data: 8'hFF, stop: 1'b0, ready: 1'b1, exp_valid: 1'b0, exp_data: 8'h00};
        vecs[2] = '{data: 8'h6E, stop: 1'b1, ready: 1'b1, exp_valid: 1'b1, exp_data: 8'h6E};

        // Reset with idle line.
        Reset = 1'b1;
        SIn = 1'b1;
        repeat (5) @(negedge Clock);
        check("reset valid", DataOutValid, 0);
        check("reset data", DataOut, 8'h00);
        check("reset state", dut.state, RX_IDLE);
`ifdef UA_RX_ERR_EN
        check("reset framing", FramingError, 0);
        check("reset overrun", Overrun, 0);
`endif
        Reset = 1'b0;
        repeat (10) @(negedge Clock);

        for (int i = 0; i < 3; i++) begin
            run_vector(vecs[i], $sformatf("vec%0d", i));
        end

        // Short low glitch on an idle line is rejected at the start-bit sample.
        rise0 = rise_cnt;
        SIn = 1'b0;
        repeat (200) @(negedge Clock);
        SIn = 1'b1;
        repeat (1000) @(negedge Clock);
        check("glitch valid_rises", rise_cnt - rise0, 0);
        check("glitch state", dut.state, RX_IDLE);
        v = '{data: 8'h3C, stop: 1'b1, ready: 1'b1, exp_valid: 1'b1, exp_data: 8'h3C};
        run_vector(v, "after_glitch");

        // Back-to-back frames with the consumer stalled: second byte is dropped.
        rise0 = rise_cnt;
        ov0   = ov_cnt;
        DataOutReady = 1'b0;
        send_frame(8'h55, 1'b1, sc);
        send_frame(8'hAA, 1'b1, sc);
        repeat (GapCycles) @(negedge Clock);
        check("b2b valid_rises", rise_cnt - rise0, 1);
        check("b2b held valid", DataOutValid, 1);
        check("b2b held data", DataOut, 8'h55);
`ifdef UA_RX_ERR_EN
        check("b2b overrun_pulses", ov_cnt - ov0, 1);
`endif
        high0 = high_cnt;
        DataOutReady = 1'b1;
        @(negedge Clock);
        DataOutReady = 1'b0;
        repeat (5) @(negedge Clock);
        check("drain valid", DataOutValid, 0);
        check("drain valid_cycles", high_cnt - high0, 1);

        // Reset 4000 cycles into a frame; the remainder of the frame must not complete.
        rise0 = rise_cnt;
        @(negedge Clock);
        for (int c = 0; c < 4000; c++) begin
            v.data = 8'hC3;
            SIn = (c < BitCycles) ? 1'b0 : v.data[(c / BitCycles) - 1];
            @(negedge Clock);
        end
        Reset = 1'b1;
        SIn = 1'b1;
        repeat (3) @(negedge Clock);
        check("midreset valid", DataOutValid, 0);
        check("midreset data", DataOut, 8'h00);
        check("midreset state", dut.state, RX_IDLE);
        Reset = 1'b0;
        repeat (4600) @(negedge Clock);
        check("midreset valid_rises", rise_cnt - rise0, 0);
        v = '{data: 8'h81, stop: 1'b1, ready: 1'b1, exp_valid: 1'b1, exp_data: 8'h81};
        run_vector(v, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
